// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding control for the in-order pipeline.
// Picks forwarding sources for EX, and inserts load-use bubbles, freezes and flushes.
module hazard_fwd_ctrl #(
    parameter int NUM_FWD = 2,
    parameter int LD_LAT = 1,
    localparam int SELW = $clog2(NUM_FWD + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [4:0]           EX_RS1,
    input  logic [4:0]           EX_RS2,
    input  logic                 EX_RS1_USED,
    input  logic                 EX_RS2_USED,
    input  logic [5*NUM_FWD-1:0] SRC_RD,
    input  logic [NUM_FWD-1:0]   SRC_REGWRITE,
    input  logic [4:0]           ID_RS1,
    input  logic [4:0]           ID_RS2,
    input  logic                 ID_RS1_USED,
    input  logic                 ID_RS2_USED,
    input  logic                 ID_VALID,
    input  logic [4:0]           EX_RD,
    input  logic                 EX_REGWRITE,
    input  logic                 EX_IS_LOAD,
    input  logic                 MEM_BUSY,
    input  logic                 FLUSH,
    output logic [SELW-1:0]      SEL_A,
    output logic [SELW-1:0]      SEL_B,
    output logic                 STALL_IF,
    output logic                 STALL_ID,
    output logic                 BUBBLE_EX,
    output logic                 FREEZE,
    output logic [15:0]          STALL_CNT,
    output logic [1:0]           HAZ_STATE
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } st_e;

    st_e         state_q;
    st_e         state_d;
    st_e         rec_q;
    st_e         rec_d;
    st_e         eff_st;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    logic [SELW-1:0] sel_a_raw;
    logic [SELW-1:0] sel_b_raw;
    logic            lu_hit;
    logic            stall;
    logic            bubble;

    // Forwarding select: scan oldest to youngest so the youngest match wins.
    always_comb begin
        sel_a_raw = '0;
        sel_b_raw = '0;
        for (int i = NUM_FWD; i >= 1; i--) begin
            if (SRC_REGWRITE[i-1] && (SRC_RD[5*i-1 -: 5] != 5'd0)) begin
                if (EX_RS1_USED && (SRC_RD[5*i-1 -: 5] == EX_RS1)) begin
                    sel_a_raw = SELW'(i);
                end
                if (EX_RS2_USED && (SRC_RD[5*i-1 -: 5] == EX_RS2)) begin
                    sel_b_raw = SELW'(i);
                end
            end
        end
    end

    // Load in EX whose result is needed by the instruction in ID.
    always_comb begin
        lu_hit = ID_VALID & EX_IS_LOAD & EX_REGWRITE & (EX_RD != 5'd0) &
                 ((ID_RS1_USED & (ID_RS1 == EX_RD)) |
                  (ID_RS2_USED & (ID_RS2 == EX_RD)));
    end

    // Next-state logic; a released MEM_WAIT behaves as the recorded state.
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        eff_st  = (state_q == MEM_WAIT) ? rec_q : state_q;
        if (MEM_BUSY) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                rec_d = state_q;
            end
        end else if (FLUSH) begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end else begin
            state_d = eff_st;
            unique case (eff_st)
                RUN: begin
                    if (lu_hit) begin
                        stall = 1'b1;
                        if (LD_LAT > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = 2'(LD_LAT - 2);
                        end
                    end
                end
                LU_STALL: begin
                    stall = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Saturating bubble counter, held while frozen since no bubble issues.
    always_comb begin
        bubble      = stall & ~RST;
        stall_cnt_d = stall_cnt_q;
        if (bubble && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State, recorded state, countdown and statistics registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            rec_q       <= RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        SEL_A     = RST ? '0 : sel_a_raw;
        SEL_B     = RST ? '0 : sel_b_raw;
        STALL_IF  = bubble;
        STALL_ID  = bubble;
        BUBBLE_EX = bubble;
        FREEZE    = MEM_BUSY & ~RST;
        STALL_CNT = stall_cnt_q;
        HAZ_STATE = RST ? 2'd0 : state_q;
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: four instances (LD_LAT 1..4, NUM_FWD 3)
// share stimulus and are compared each cycle against a bubbles-owed model.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_rs1, ex_rs2, id_rs1, id_rs2, ex_rd;
    logic        ex_rs1_used, ex_rs2_used;
    logic [14:0] src_rd;
    logic [2:0]  src_regwrite;
    logic        id_rs1_used, id_rs2_used, id_valid;
    logic        ex_regwrite, ex_is_load, mem_busy, flush;

    logic [1:0]  sel_a [4];
    logic [1:0]  sel_b [4];
    logic        stall_if [4];
    logic        stall_id [4];
    logic        bubble [4];
    logic        freeze [4];
    logic [15:0] stall_cnt [4];
    logic [1:0]  haz [4];

    int n_chk = 0;
    int n_fail = 0;

    int m_rem [4];
    bit m_wait [4];
    int m_sc [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hazard_fwd_ctrl #(.NUM_FWD(3), .LD_LAT(g + 1)) u_dut (
            .CLK(clk), .RST(rst),
            .EX_RS1(ex_rs1), .EX_RS2(ex_rs2),
            .EX_RS1_USED(ex_rs1_used), .EX_RS2_USED(ex_rs2_used),
            .SRC_RD(src_rd), .SRC_REGWRITE(src_regwrite),
            .ID_RS1(id_rs1), .ID_RS2(id_rs2),
            .ID_RS1_USED(id_rs1_used), .ID_RS2_USED(id_rs2_used),
            .ID_VALID(id_valid), .EX_RD(ex_rd),
            .EX_REGWRITE(ex_regwrite), .EX_IS_LOAD(ex_is_load),
            .MEM_BUSY(mem_busy), .FLUSH(flush),
            .SEL_A(sel_a[g]), .SEL_B(sel_b[g]),
            .STALL_IF(stall_if[g]), .STALL_ID(stall_id[g]),
            .BUBBLE_EX(bubble[g]), .FREEZE(freeze[g]),
            .STALL_CNT(stall_cnt[g]), .HAZ_STATE(haz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, g, act, exp, $time);
        end
    endtask

    function automatic int msel(input logic [14:0] rd, input logic [2:0] wr,
                                input logic [4:0] rs, input logic used);
        logic [14:0] v;
        v = rd;
        for (int i = 1; i <= 3; i++) begin
            if (used && wr[i-1] && v[4:0] != 5'd0 && v[4:0] == rs) return i;
            v = v >> 5;
        end
        return 0;
    endfunction

    // Reference: each instance owes some bubbles; a hit in an idle cycle owes LD_LAT.
    always @(negedge clk) begin
        int ea, eb, eh;
        bit lu, bub;
        ea = rst ? 0 : msel(src_rd, src_regwrite, ex_rs1, ex_rs1_used);
        eb = rst ? 0 : msel(src_rd, src_regwrite, ex_rs2, ex_rs2_used);
        lu = id_valid && ex_is_load && ex_regwrite && ex_rd != 5'd0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        for (int g = 0; g < 4; g++) begin
            bub = 1'b0;
            if (!rst && !mem_busy && !flush) bub = (m_rem[g] > 0) || lu;
            eh = rst ? 0 : (m_wait[g] ? 2 : (m_rem[g] > 0 ? 1 : 0));
            chk("sel_a", g, int'(sel_a[g]), ea);
            chk("sel_b", g, int'(sel_b[g]), eb);
            chk("stall_if", g, int'(stall_if[g]), int'(bub));
            chk("stall_id", g, int'(stall_id[g]), int'(bub));
            chk("bubble_ex", g, int'(bubble[g]), int'(bub));
            chk("freeze", g, int'(freeze[g]), int'(!rst && mem_busy));
            chk("haz_state", g, int'(haz[g]), eh);
            if (!rst) chk("stall_cnt", g, int'(stall_cnt[g]), m_sc[g]);
            if (rst) begin
                m_rem[g] = 0;
                m_wait[g] = 1'b0;
                m_sc[g] = 0;
            end else begin
                if (!mem_busy) begin
                    if (flush) m_rem[g] = 0;
                    else if (m_rem[g] > 0) m_rem[g]--;
                    else if (lu) m_rem[g] = g;
                end
                m_wait[g] = mem_busy;
                if (bub && m_sc[g] < 65535) m_sc[g]++;
            end
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        ex_rs1 = 0; ex_rs2 = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_rs1_used = 0; ex_rs2_used = 0; src_rd = 0; src_regwrite = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_valid = 0;
        ex_regwrite = 0; ex_is_load = 0; mem_busy = 0; flush = 0;
    endtask

    task automatic do_reset();
        nx();
        clr();
        rst = 1;
        smp();
        nx();
        rst = 0;
    endtask

    task automatic hit();
        id_valid = 1; ex_is_load = 1; ex_regwrite = 1;
        ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1;
    endtask

    initial begin
        int b, f, h2;
        rst = 1;
        clr();
        for (int g = 0; g < 4; g++) begin
            m_rem[g] = 0; m_wait[g] = 0; m_sc[g] = 0;
        end
        do_reset();

        // forwarding priority, and selects stay live while frozen
        src_regwrite = 3'b011;
        src_rd = {5'd0, 5'd5, 5'd5};
        ex_rs1 = 5'd5; ex_rs1_used = 1;
        smp();
        chk("prio_both", 0, int'(sel_a[0]), 1);
        nx();
        src_rd = {5'd0, 5'd5, 5'd0};
        smp();
        chk("prio_rd0", 0, int'(sel_a[0]), 2);
        nx();
        ex_rs1_used = 0;
        smp();
        chk("prio_unused", 0, int'(sel_a[0]), 0);
        nx();
        src_regwrite = 3'b100; src_rd = {5'd9, 5'd0, 5'd0};
        ex_rs2 = 5'd9; ex_rs2_used = 1; mem_busy = 1;
        smp();
        chk("selb_src3_frz", 0, int'(sel_b[0]), 3);
        chk("frz_out", 0, int'(freeze[0]), 1);

        // load-use on LD_LAT=2
        do_reset();
        nx(); hit(); smp();
        b = bubble[1];
        chk("lu_haz0", 1, int'(haz[1]), 0);
        nx(); clr(); smp();
        b += bubble[1];
        chk("lu_haz1", 1, int'(haz[1]), 1);
        nx(); smp();
        b += bubble[1];
        chk("lu_haz_back", 1, int'(haz[1]), 0);
        repeat (3) begin nx(); smp(); b += bubble[1]; end
        chk("lu_bubbles", 1, b, 2);
        chk("lu_cnt", 1, int'(stall_cnt[1]), 2);

        // freeze after the first bubble on LD_LAT=3
        do_reset();
        nx(); hit(); smp();
        b = bubble[2]; f = 0; h2 = 0;
        nx(); clr(); mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            f += freeze[2]; b += bubble[2]; h2 += (haz[2] == 2'd2);
            nx();
        end
        mem_busy = 0;
        for (int i = 0; i < 6; i++) begin
            smp();
            f += freeze[2]; b += bubble[2]; h2 += (haz[2] == 2'd2);
            nx();
        end
        smp();
        chk("frz_cycles", 2, f, 4);
        chk("frz_haz2", 2, h2, 4);
        chk("frz_bubbles", 2, b, 3);
        chk("frz_cnt", 2, int'(stall_cnt[2]), 3);

        // flush during the stall on LD_LAT=4
        do_reset();
        nx(); hit(); smp();
        chk("fl_hit_bub", 3, int'(bubble[3]), 1);
        nx(); clr(); flush = 1; smp();
        chk("fl_bub", 3, int'(bubble[3]), 0);
        chk("fl_haz", 3, int'(haz[3]), 1);
        nx(); flush = 0; smp();
        chk("fl_haz_after", 3, int'(haz[3]), 0);
        chk("fl_cnt", 3, int'(stall_cnt[3]), 1);

        // counter saturation under continuous load-use hits
        do_reset();
        nx(); hit(); smp();
        for (int i = 0; i < 65533; i++) begin nx(); smp(); end
        nx(); smp();
        chk("sat_fffe", 0, int'(stall_cnt[0]), 32'hFFFE);
        nx(); smp();
        nx(); smp();
        nx(); clr(); smp();
        chk("sat_ffff", 0, int'(stall_cnt[0]), 32'hFFFF);
        chk("sat_ffff", 3, int'(stall_cnt[3]), 32'hFFFF);

        // reset in the middle of a stall
        nx(); hit(); smp();
        nx(); clr(); rst = 1; smp();
        chk("rst_bub", 3, int'(bubble[3]), 0);
        chk("rst_stall", 3, int'(stall_if[3]), 0);
        chk("rst_haz", 3, int'(haz[3]), 0);
        nx(); rst = 0; smp();
        chk("rst_cnt", 3, int'(stall_cnt[3]), 0);
        chk("rst_cnt", 0, int'(stall_cnt[0]), 0);
        chk("rst_haz_after", 3, int'(haz[3]), 0);
        chk("rst_bub_after", 3, int'(bubble[3]), 0);

        // random traffic with small register range for frequent matches
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            nx();
            rst = ($urandom_range(0, 99) == 0);
            mem_busy = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            ex_rs1 = 5'($urandom_range(0, 3));
            ex_rs2 = 5'($urandom_range(0, 3));
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            src_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3))};
            src_regwrite = 3'($urandom_range(0, 7));
            ex_rs1_used = 1'($urandom_range(0, 1));
            ex_rs2_used = 1'($urandom_range(0, 1));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_valid = ($urandom_range(0, 3) != 0);
            ex_regwrite = ($urandom_range(0, 3) != 0);
            ex_is_load = 1'($urandom_range(0, 1));
            smp();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_FWD, 2, number of forwarding source stages after EX; 2..4; index 1 is youngest (EX/MEM).
- LD_LAT, 1, load-use bubble cycles; 1..4.
- SELW, $clog2(NUM_FWD+1), select width; derived, not overridable.
REQ-002 SHALL have ports, one per line:
- CLK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- EX_RS1, EX_RS2  in  5 each  source registers of the instruction in EX.
- EX_RS1_USED, EX_RS2_USED  in  1 each  operand actually read.
- SRC_RD  in  5*NUM_FWD  destination reg of source i, packed at bits [5i-1:5i-5].
- SRC_REGWRITE  in  NUM_FWD  source i writes the register file.
- ID_RS1, ID_RS2  in  5 each  source registers of the instruction in ID.
- ID_RS1_USED, ID_RS2_USED, ID_VALID  in  1 each  operand used; ID holds a valid instruction.
- EX_RD  in  5  destination of the instruction in EX.
- EX_REGWRITE, EX_IS_LOAD  in  1 each  EX writes a register; EX is a load.
- MEM_BUSY  in  1  data memory has not completed; freezes the pipeline.
- FLUSH  in  1  taken branch/jump; ID and EX contents are discarded.
- SEL_A, SEL_B  out  SELW each  0 = register file, i = forward from source i.
- STALL_IF, STALL_ID  out  1 each  hold the PC and IF/ID registers.
- BUBBLE_EX  out  1  load a NOP into ID/EX.
- FREEZE  out  1  hold every pipeline register.
- STALL_CNT  out  16  saturating count of load-use bubble cycles.
- HAZ_STATE  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT.

Function
REQ-003 SHALL drive SEL_A combinationally as the lowest i for which all of the following hold: SRC_REGWRITE[i], SRC_RD_i != 0, SRC_RD_i == EX_RS1, and EX_RS1_USED. SEL_A SHALL be 0 when no source matches. SEL_B SHALL use the same rule with EX_RS2 and EX_RS2_USED.
REQ-004 SHALL define LU_HIT = ID_VALID & EX_IS_LOAD & EX_REGWRITE & EX_RD != 0 & ((ID_RS1_USED & ID_RS1 == EX_RD) | (ID_RS2_USED & ID_RS2 == EX_RD)).
REQ-005 SHALL implement the FSM states RUN, LU_STALL and MEM_WAIT, with a 2-bit down-counter CNT.
REQ-006 In RUN with LU_HIT & !FLUSH & !MEM_BUSY, SHALL assert STALL_IF, STALL_ID and BUBBLE_EX that same cycle. If LD_LAT > 1, the next state SHALL be LU_STALL with CNT = LD_LAT-2; otherwise the FSM SHALL stay in RUN.
REQ-007 In LU_STALL, SHALL assert STALL_IF, STALL_ID and BUBBLE_EX every cycle.
- If CNT == 0: next state RUN.
- Otherwise: CNT decrements.
Total bubbles per hit SHALL be exactly LD_LAT.
REQ-008 SHALL assert FREEZE combinationally whenever MEM_BUSY = 1, in any state. While FREEZE is asserted:
- STALL_IF, STALL_ID and BUBBLE_EX SHALL be 0.
- CNT SHALL hold.
- STALL_CNT SHALL hold.
REQ-009 On MEM_BUSY = 1, SHALL record the pre-freeze state (RUN or LU_STALL) and go to MEM_WAIT. On the first cycle with MEM_BUSY = 0, SHALL return to the recorded state with CNT unchanged.
REQ-010 FLUSH = 1 with MEM_BUSY = 0, from any state, SHALL:
- force next state RUN and CNT to 0;
- suppress LU_HIT that cycle;
- deassert STALL_IF, STALL_ID and BUBBLE_EX that cycle.
REQ-011 When MEM_BUSY and FLUSH are both 1, MEM_BUSY SHALL win. The flush SHALL be applied on the first non-busy cycle only if FLUSH is still asserted then.
REQ-012 STALL_CNT SHALL increment by 1 on each cycle with BUBBLE_EX = 1. It SHALL saturate at 16'hFFFF.
REQ-013 SEL_A and SEL_B SHALL stay valid during FREEZE and stall cycles; they are purely combinational.

Reset
REQ-014 With RST = 1 at a rising edge, SHALL set state RUN, CNT 0, recorded state RUN, and STALL_CNT 0.
REQ-015 While RST = 1, SHALL drive STALL_IF, STALL_ID, BUBBLE_EX, FREEZE, SEL_A and SEL_B to 0, and HAZ_STATE to 0. Reset asserted mid-LU_STALL or mid-MEM_WAIT SHALL abort the sequence with no further bubbles.

Verification
REQ-016 SHALL be covered by these directed scenarios:
- Priority: NUM_FWD = 3, sources 1 and 2 both write x5, EX_RS1 = 5 -> SEL_A = 1. With source 1 RD = 0 -> SEL_A = 2. With EX_RS1_USED = 0 -> SEL_A = 0.
- Load-use: LD_LAT = 2, EX load to x7, ID_RS2 = 7 used -> BUBBLE_EX high exactly 2 cycles, HAZ_STATE 0 -> 1 -> 0, STALL_CNT = 2.
- Freeze mid-stall: LD_LAT = 3, MEM_BUSY high for 4 cycles after the first bubble -> FREEZE high 4 cycles, HAZ_STATE = 2, total bubbles still 3.
- Flush: FLUSH asserted in the second cycle of LU_STALL (LD_LAT = 4) -> bubbles stop that cycle, HAZ_STATE = 0 next cycle, STALL_CNT = 1.
- Saturation and reset: preload to 16'hFFFE, 3 bubbles -> STALL_CNT = 16'hFFFF. RST asserted mid-stall -> all outputs 0 that cycle and the counter cleared next edge.
